hit_collector: RTL and testbench
================================

Name: hit_collector

Overview:
Collects match hits from LANES parallel comparer lanes, each with a registered candidate key and a single-cycle hit strobe. Holds one pending hit per lane and grants lanes round-robin into a shared hit FIFO. Drains the FIFO to the host I/O side over a valid/ready stream. Sits between the comparer array and the host readout logic, so no hit is lost silently: drops are counted.

Parameters:
LANES, 4, number of comparer lanes (2..16)
WIDTH, 64, key width in bits
FIFO_DEPTH, 8, hit FIFO entries; power of two, >= 2
CNT_W, 16, width of the dropped-hit counter

Ports:
CLK  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  1 = accept new lane hits; 0 = ignore hits, keep draining
flush  in  1  synchronous clear of pending slots, FIFO and drop counter
lane_hit  in  LANES  per-lane hit strobe, sampled every cycle
lane_key  in  LANES*WIDTH  per-lane key; lane i at bits [i*WIDTH +: WIDTH]
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_key  out  WIDTH  key at FIFO head
out_lane  out  clog2(LANES)  source lane of head
pending  out  LANES  per-lane slot occupied
fifo_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
dropped_cnt  out  CNT_W  hits lost because the lane slot was occupied; saturating
idle  out  1  no pending slots, FIFO empty

Behaviour:
- Reset (reset_n=0, async): all slots empty, FIFO empty, round-robin pointer=0, dropped_cnt=0. Outputs: out_valid=0, out_key=0, out_lane=0, pending=0, fifo_count=0, idle=1.
- Capture: on a rising edge with enable=1 and lane_hit[i]=1:
  - If slot i is empty, or slot i is granted this same cycle, latch lane_key[i] and set pending[i].
  - Otherwise the hit is dropped and dropped_cnt increments by 1.
  - Several lanes dropping in the same cycle add their count (popcount). The sum saturates at all-ones.
- Grant: each cycle, if any slot is pending and the FIFO is not full (the same-cycle pop counts as freeing space), grant exactly one lane.
  - The granted lane is the first pending lane searching from rr_ptr upward, with wrap-around.
  - The FIFO writes {lane, key}, the slot clears, and rr_ptr becomes grant+1 mod LANES.
  - With no grant, rr_ptr holds.
- FIFO full with no pop: no grant, slots hold, and captures into occupied slots drop.
- Latency: hit sampled at edge t gives pending=1 after t; FIFO write at edge t+1; out_valid=1 after t+1. Minimum is 2 cycles hit-to-out_valid.
- Output: out_valid = FIFO non-empty. Pop on out_valid && out_ready. out_key and out_lane are stable while out_valid && !out_ready. Simultaneous push and pop leaves fifo_count unchanged.
- enable=0: lane_hit is ignored and not counted as dropped; grants and drain continue.
- flush=1 has priority over capture, grant, pop and count.
  - Next cycle: slots empty, FIFO empty, dropped_cnt=0, rr_ptr=0.
  - Hits presented during the flush cycle are discarded.
- Reset asserted mid-operation clears everything immediately. No partial output is held.
- idle = (pending==0) && (fifo_count==0).

Decomposition:
- Package hit_collector_pkg:
  - LANE_W = clog2(LANES) helper function
  - Entry layout constant: key at LSBs, lane at MSBs
  - Saturating-add helper function
- Sub-module hit_fifo: synchronous, parameterised width and depth, wrap-around pointers with an extra full/empty bit, count output, async active-low reset, synchronous flush.
- Slots, round-robin grant and drop counting stay in the top module.

Test Plan:
- Single hit: LANES=4, lane 2 hit with key 64'h0123_4567_89AB_CDEF, out_ready=1 -> out_valid two cycles later, out_lane=2, key matches; idle returns to 1 after the pop.
- Simultaneous hits: lanes 0..3 hit in the same cycle, rr_ptr=0 -> outputs in lane order 0,1,2,3 on consecutive cycles. Repeat with rr_ptr=2 -> order 2,3,0,1.
- Back-pressure: out_ready=0, 12 hits spread over all lanes, FIFO_DEPTH=8 -> fifo_count=8, all 4 slots pending, further hits increment dropped_cnt exactly. Raise out_ready -> 12 entries drain in grant order.
- Re-hit on pending lane: lane 1 hit twice, FIFO full -> dropped_cnt=1. Hit on the grant cycle -> accepted, no drop.
- Saturation and enable: CNT_W=4, force 20 drops -> dropped_cnt=4'hF. With enable=0, hits on all lanes -> no capture, counter unchanged.
- Flush and reset: FIFO at 5 entries, 2 slots pending, pulse flush -> next cycle all zero and idle=1. Assert reset_n=0 asynchronously mid-drain -> out_valid falls without waiting for a clock edge.

Source files
------------

// File: rtl/hit_collector_pkg.sv
// Shared constants and helpers for the hit collector.
package hit_collector_pkg;

  // A FIFO entry packs the key at the LSBs and the source lane directly above it.
  localparam int KEY_LSB = 0;

  // Bits needed to name a lane. Never less than 1, so LANES=2 still gets a real field.
  function automatic int lane_w(input int lanes);
    return (lanes <= 2) ? 1 : $clog2(lanes);
  endfunction

  // Total width of one FIFO entry.
  function automatic int entry_w(input int key_w, input int lane_bits);
    return key_w + lane_bits;
  endfunction

  // Adds b to a and clamps the result at max.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max}) return max;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/hit_fifo.sv
// Synchronous FIFO. Pointers carry one extra wrap bit, which tells full and empty apart.
module hit_fifo #(
  parameter int W     = 66,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_do_push;
  logic         w_do_pop;

  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign count     = r_wptr - r_rptr;
  assign pop_data  = r_mem[r_rptr[AW-1:0]];
  assign w_do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is allowed then.
  assign w_do_push = push && (!full || w_do_pop);

  // Pointer update. Flush empties the FIFO and overrides any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage write. No reset is needed: stale contents are never visible while empty.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/hit_collector.sv
// Collects single-cycle lane hits into per-lane slots and grants them round-robin into a
// shared FIFO. Hits that find their slot occupied are counted as drops, never lost silently.
//
// out_valid/out_ready: an entry transfers on a rising edge where both are high. Once
// out_valid rises, it stays high and out_key/out_lane hold steady until that transfer.
module hit_collector
  import hit_collector_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int WIDTH      = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                        CLK,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        flush,
  input  logic [LANES-1:0]            lane_hit,
  input  logic [LANES*WIDTH-1:0]      lane_key,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_key,
  output logic [lane_w(LANES)-1:0]    out_lane,
  output logic [LANES-1:0]            pending,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]            dropped_cnt,
  output logic                        idle
);
  localparam int          LANE_W  = lane_w(LANES);
  localparam int          ENTRY_W = entry_w(WIDTH, LANE_W);
  localparam logic [31:0] CNT_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CNT_W) - 32'd1);

  logic [LANES-1:0]  r_pending;
  logic [WIDTH-1:0]  r_key [LANES];
  logic [LANE_W-1:0] r_rr_ptr;
  logic [CNT_W-1:0]  r_dropped;

  logic              w_grant_vld;
  logic [LANE_W-1:0] w_grant_idx;
  logic [LANES-1:0]  w_capture;
  logic [31:0]       w_drop_num;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_pop;
  logic              w_can_push;
  logic [ENTRY_W-1:0] w_push_data;
  logic [ENTRY_W-1:0] w_head;

  // Lane reached by stepping off lanes upward from base, with wrap-around.
  function automatic logic [LANE_W-1:0] step_lane(input logic [LANE_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= LANES) s = s - LANES;
    return LANE_W'(s);
  endfunction

  assign w_pop      = !w_fifo_empty && out_ready;
  assign w_can_push = !w_fifo_full || w_pop;

  // Round-robin grant: the first pending lane at or above rr_ptr, when the FIFO has room.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < LANES; k++) begin
      if (!w_grant_vld && r_pending[step_lane(r_rr_ptr, k)]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = step_lane(r_rr_ptr, k);
      end
    end
    if (!w_can_push) w_grant_vld = 1'b0;
  end

  // Capture or drop decision per lane. A slot that is granted this cycle counts as free.
  always_comb begin
    w_capture  = '0;
    w_drop_num = '0;
    for (int i = 0; i < LANES; i++) begin
      if (enable && lane_hit[i]) begin
        if (!r_pending[i] || (w_grant_vld && (w_grant_idx == LANE_W'(i)))) w_capture[i] = 1'b1;
        else w_drop_num = w_drop_num + 32'd1;
      end
    end
  end

  // Slot occupancy, round-robin pointer and drop counter. Flush has priority over everything.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_rr_ptr  <= '0;
      r_dropped <= '0;
    end else if (flush) begin
      r_pending <= '0;
      r_rr_ptr  <= '0;
      r_dropped <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (w_capture[i]) r_pending[i] <= 1'b1;
        else if (w_grant_vld && (w_grant_idx == LANE_W'(i))) r_pending[i] <= 1'b0;
      end
      if (w_grant_vld) r_rr_ptr <= step_lane(w_grant_idx, 1);
      r_dropped <= CNT_W'(sat_add(32'(r_dropped), w_drop_num, CNT_MAX));
    end
  end

  // Slot keys. Only meaningful while the matching pending bit is set, so no reset.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < LANES; i++) begin
      if (w_capture[i] && !flush) r_key[i] <= lane_key[i*WIDTH +: WIDTH];
    end
  end

  assign w_push_data = {w_grant_idx, r_key[w_grant_idx]};

  hit_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (reset_n),
    .flush     (flush),
    .push      (w_grant_vld),
    .push_data (w_push_data),
    .pop       (w_pop),
    .pop_data  (w_head),
    .empty     (w_fifo_empty),
    .full      (w_fifo_full),
    .count     (fifo_count)
  );

  assign out_valid   = !w_fifo_empty;
  assign out_key     = out_valid ? w_head[KEY_LSB +: WIDTH] : '0;
  assign out_lane    = out_valid ? w_head[WIDTH +: LANE_W] : '0;
  assign pending     = r_pending;
  assign dropped_cnt = r_dropped;
  assign idle        = (r_pending == '0) && w_fifo_empty;

endmodule

// File: tb/tb_hit_collector.sv
// Bench for hit_collector: directed scenarios with a scoreboard of expected {lane, key} entries.
module tb_hit_collector;
  localparam int LANES = 4;
  localparam int WIDTH = 64;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic                   CLK;
  logic                   reset_n;
  logic                   enable;
  logic                   flush;
  logic [LANES-1:0]       lane_hit;
  logic [LANES*WIDTH-1:0] lane_key;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_key;
  logic [1:0]             out_lane;
  logic [LANES-1:0]       pending;
  logic [3:0]             fifo_count;
  logic [CNT_W-1:0]       dropped_cnt;
  logic                   idle;

  int checks = 0;
  int errors = 0;
  logic [WIDTH+1:0] exp_q[$];
  logic [WIDTH+1:0] sb_exp;

  hit_collector #(
    .LANES(LANES), .WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .reset_n(reset_n), .enable(enable), .flush(flush),
    .lane_hit(lane_hit), .lane_key(lane_key), .out_valid(out_valid), .out_ready(out_ready),
    .out_key(out_key), .out_lane(out_lane), .pending(pending), .fifo_count(fifo_count),
    .dropped_cnt(dropped_cnt), .idle(idle)
  );

  // Clock and watchdog
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Scoreboard: every accepted output beat is compared against the head of exp_q.
  always @(negedge CLK) begin
    if (reset_n && !flush && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got lane=%0d key=%h want no entry", out_lane, out_key);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({out_lane, out_key} !== sb_exp) begin
          errors++;
          $display("FAIL sb_entry got lane=%0d key=%h want lane=%0d key=%h",
                   out_lane, out_key, sb_exp[WIDTH +: 2], sb_exp[WIDTH-1:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic hit_lane(input int lane, input logic [WIDTH-1:0] key, input bit expect_out);
    lane_hit[2'(lane)] = 1'b1;
    lane_key[lane*WIDTH +: WIDTH] = key;
    if (expect_out) exp_q.push_back({2'(lane), key});
  endtask

  task automatic do_flush();
    lane_hit = '0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && !(idle && exp_q.size() == 0); i++) tick();
    checks++;
    if (!(idle && exp_q.size() == 0)) begin
      errors++;
      $display("FAIL drain_timeout got idle=%0b queued=%0d want idle=1 queued=0", idle, exp_q.size());
    end
  endtask

  // Scenarios
  task automatic test_reset();
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    checks++; if (out_key !== '0) begin errors++; $display("FAIL reset_key got=%h want=0", out_key); end
    checks++; if (out_lane !== 2'd0) begin errors++; $display("FAIL reset_lane got=%0d want=0", out_lane); end
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL reset_pending got=%b want=0000", pending); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
    checks++; if (dropped_cnt !== 4'd0) begin errors++; $display("FAIL reset_dropped got=%0d want=0", dropped_cnt); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%0b want=1", idle); end
    @(negedge CLK);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_hit();
    out_ready = 1'b1;
    hit_lane(2, 64'h0123_4567_89AB_CDEF, 1);
    tick();
    lane_hit = '0;
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL single_pending got=%b want=0100", pending); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%0b want=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b want=1", out_valid); end
    checks++; if (out_lane !== 2'd2) begin errors++; $display("FAIL single_lane got=%0d want=2", out_lane); end
    checks++; if (out_key !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL single_key got=%h want=0123456789abcdef", out_key); end
    tick();
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle got=%0b want=1", idle); end
  endtask

  task automatic test_simultaneous();
    int ord[4];
    do_flush();
    out_ready = 1'b1;
    for (int l = 0; l < LANES; l++) hit_lane(l, {$urandom, $urandom}, 1);
    tick();
    lane_hit = '0;
    checks++; if (pending !== 4'hF) begin errors++; $display("FAIL simul_pending got=%b want=1111", pending); end
    for (int c = 0; c < LANES; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_lane !== 2'(c)) begin
        errors++; $display("FAIL simul_order0 got valid=%0b lane=%0d want valid=1 lane=%0d", out_valid, out_lane, c);
      end
    end
    wait_drain(10);
    // A lone hit on lane 1 leaves the round-robin pointer at 2.
    hit_lane(1, {$urandom, $urandom}, 1);
    tick();
    lane_hit = '0;
    wait_drain(10);
    ord = '{2, 3, 0, 1};
    for (int c = 0; c < LANES; c++) hit_lane(ord[c], {$urandom, $urandom}, 1);
    tick();
    lane_hit = '0;
    for (int c = 0; c < LANES; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_lane !== 2'(ord[c])) begin
        errors++; $display("FAIL simul_order2 got valid=%0b lane=%0d want valid=1 lane=%0d", out_valid, out_lane, ord[c]);
      end
    end
    wait_drain(10);
  endtask

  task automatic test_back_pressure();
    do_flush();
    out_ready = 1'b0;
    for (int l = 0; l < LANES; l++) hit_lane(l, {$urandom, $urandom}, 1);
    tick();
    // Each cycle re-hit the lane being granted, so every hit is accepted.
    for (int k = 0; k < 8; k++) begin
      lane_hit = '0;
      hit_lane(k % LANES, {$urandom, $urandom}, 1);
      tick();
    end
    lane_hit = '0;
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL bp_count got=%0d want=8", fifo_count); end
    checks++; if (pending !== 4'hF) begin errors++; $display("FAIL bp_pending got=%b want=1111", pending); end
    checks++; if (dropped_cnt !== 4'd0) begin errors++; $display("FAIL bp_nodrop got=%0d want=0", dropped_cnt); end
    hit_lane(1, {$urandom, $urandom}, 0);
    hit_lane(3, {$urandom, $urandom}, 0);
    tick();
    lane_hit = '0;
    checks++; if (dropped_cnt !== 4'd2) begin errors++; $display("FAIL bp_drop2 got=%0d want=2", dropped_cnt); end
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL bp_full_hold got=%0d want=8", fifo_count); end
    hit_lane(1, {$urandom, $urandom}, 0);
    tick();
    lane_hit = '0;
    checks++; if (dropped_cnt !== 4'd3) begin errors++; $display("FAIL bp_drop3 got=%0d want=3", dropped_cnt); end
    out_ready = 1'b1;
    wait_drain(40);
    checks++; if (dropped_cnt !== 4'd3) begin errors++; $display("FAIL bp_drop_after got=%0d want=3", dropped_cnt); end
  endtask

  task automatic test_rehit();
    do_flush();
    out_ready = 1'b1;
    hit_lane(0, {$urandom, $urandom}, 1);
    hit_lane(1, {$urandom, $urandom}, 1);
    tick();
    lane_hit = '0;
    checks++; if (pending !== 4'b0011) begin errors++; $display("FAIL rehit_pending got=%b want=0011", pending); end
    // Lane 0 is granted this cycle; lane 1 is still occupied, so this hit drops.
    hit_lane(1, {$urandom, $urandom}, 0);
    tick();
    lane_hit = '0;
    checks++; if (dropped_cnt !== 4'd1) begin errors++; $display("FAIL rehit_drop got=%0d want=1", dropped_cnt); end
    // Lane 1 is granted this cycle, so the new hit is accepted.
    hit_lane(1, {$urandom, $urandom}, 1);
    tick();
    lane_hit = '0;
    checks++; if (dropped_cnt !== 4'd1) begin errors++; $display("FAIL rehit_grant_cycle got=%0d want=1", dropped_cnt); end
    checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL rehit_recaptured got=%b want=0010", pending); end
    wait_drain(10);
  endtask

  task automatic test_saturation_enable();
    do_flush();
    out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      for (int l = 0; l < LANES; l++) hit_lane(l, {$urandom, $urandom}, 0);
      tick();
    end
    checks++; if (dropped_cnt !== 4'hF) begin errors++; $display("FAIL sat_value got=%h want=f", dropped_cnt); end
    enable = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    checks++; if (dropped_cnt !== 4'hF) begin errors++; $display("FAIL sat_disabled got=%h want=f", dropped_cnt); end
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL sat_disabled_count got=%0d want=8", fifo_count); end
    do_flush();
    lane_hit = 4'hF;
    for (int c = 0; c < 3; c++) tick();
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL en0_pending got=%b want=0000", pending); end
    checks++; if (dropped_cnt !== 4'd0) begin errors++; $display("FAIL en0_dropped got=%0d want=0", dropped_cnt); end
    // One accepted hit, then enable drops while the entry is still to be granted and drained.
    lane_hit = '0;
    enable = 1'b1;
    out_ready = 1'b1;
    hit_lane(3, {$urandom, $urandom}, 1);
    tick();
    enable = 1'b0;
    lane_hit = 4'hF;
    wait_drain(10);
    checks++; if (dropped_cnt !== 4'd0) begin errors++; $display("FAIL en0_drain_dropped got=%0d want=0", dropped_cnt); end
    lane_hit = '0;
    enable = 1'b1;
  endtask

  task automatic test_flush();
    do_flush();
    out_ready = 1'b0;
    for (int l = 0; l < LANES; l++) hit_lane(l, {$urandom, $urandom}, 0);
    tick();
    lane_hit = '0; hit_lane(0, {$urandom, $urandom}, 0); tick();
    lane_hit = '0; hit_lane(1, {$urandom, $urandom}, 0); tick();
    lane_hit = '0; tick();
    tick();
    hit_lane(3, {$urandom, $urandom}, 0);
    tick();
    lane_hit = '0;
    checks++; if (fifo_count !== 4'd5) begin errors++; $display("FAIL flush_pre_count got=%0d want=5", fifo_count); end
    checks++; if (pending !== 4'b1010) begin errors++; $display("FAIL flush_pre_pending got=%b want=1010", pending); end
    flush = 1'b1;
    out_ready = 1'b1;
    hit_lane(0, {$urandom, $urandom}, 0);
    tick();
    flush = 1'b0;
    lane_hit = '0;
    exp_q.delete();
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL flush_pending got=%b want=0000", pending); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL flush_count got=%0d want=0", fifo_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b want=0", out_valid); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL flush_idle got=%0b want=1", idle); end
    tick();
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL flush_hit_discard got=%b want=0000", pending); end
  endtask

  task automatic test_reset_mid_drain();
    out_ready = 1'b0;
    for (int l = 0; l < LANES; l++) hit_lane(l, {$urandom, $urandom}, 1);
    tick();
    lane_hit = '0;
    for (int c = 0; c < 3; c++) tick();
    out_ready = 1'b1;
    tick();
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%0b want=0", out_valid); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL arst_count got=%0d want=0", fifo_count); end
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL arst_pending got=%b want=0000", pending); end
    checks++; if (out_key !== '0) begin errors++; $display("FAIL arst_key got=%h want=0", out_key); end
    exp_q.delete();
    @(negedge CLK);
    reset_n = 1'b1;
    tick();
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL arst_idle got=%0b want=1", idle); end
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b1;
    flush     = 1'b0;
    lane_hit  = '0;
    lane_key  = '0;
    out_ready = 1'b0;
    test_reset();
    test_single_hit();
    test_simultaneous();
    test_back_pressure();
    test_rehit();
    test_saturation_enable();
    test_flush();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
